// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module     : y86_pkg
// Description: Shared Y86-64 constants: instruction codes, register indices
//              and status codes used by the writeback stage.
// Revision   : 1.0 - initial release
// ============================================================================
package y86_pkg;

   // Instruction codes
   localparam logic [3:0] INOP    = 4'd1;
   localparam logic [3:0] ICMOVXX = 4'd2;
   localparam logic [3:0] IIRMOVQ = 4'd3;
   localparam logic [3:0] IMRMOVQ = 4'd5;
   localparam logic [3:0] IOPQ    = 4'd6;
   localparam logic [3:0] ICALL   = 4'd8;
   localparam logic [3:0] IRET    = 4'd9;
   localparam logic [3:0] IPUSHQ  = 4'd10;
   localparam logic [3:0] IPOPQ   = 4'd11;

   // Register indices
   localparam logic [3:0] RNONE   = 4'hF;
   localparam logic [3:0] RRSP    = 4'd4;

   // Status codes
   localparam logic [2:0] SBUB    = 3'd0;
   localparam logic [2:0] SAOK    = 3'd1;
   localparam logic [2:0] SHLT    = 3'd2;
   localparam logic [2:0] SADR    = 3'd3;
   localparam logic [2:0] SINS    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/y86_regfile.sv
`default_nettype none
// ============================================================================
// Module     : y86_regfile
// Description: NREG x DATA_W register file, two write ports (M wins on equal
//              index) and two combinational read ports. Indices >= NREG read
//              as zero. With WB_BYPASS_EN defined, reads see the pending
//              writes of the current cycle (M first, then E).
// Revision   : 1.0 - initial release
// ============================================================================
module y86_regfile #(
   parameter int DATA_W = 64,
   parameter int NREG   = 15,
   parameter int RA_W   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we_e,
   input  logic [RA_W-1:0]        dst_e,
   input  logic [DATA_W-1:0]      val_e,
   input  logic                   we_m,
   input  logic [RA_W-1:0]        dst_m,
   input  logic [DATA_W-1:0]      val_m,
   input  logic [RA_W-1:0]        src_a,
   input  logic [RA_W-1:0]        src_b,
   output logic [DATA_W-1:0]      rval_a,
   output logic [DATA_W-1:0]      rval_b,
   output logic [NREG*DATA_W-1:0] reg_dump
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   // Read one port: stored value, optionally overridden by the pending writes
   function automatic logic [DATA_W-1:0] rd_port(input logic [RA_W-1:0] src);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < NREG; i++) begin
         if (src == RA_W'(i)) v = regs_q[i];
      end
`ifdef WB_BYPASS_EN
      if (we_m && (dst_m == src))      v = val_m;
      else if (we_e && (dst_e == src)) v = val_e;
`endif
      return v;
   endfunction

   // Next register contents; port M is applied last so it wins on a shared index
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
         if (we_e && (dst_e == RA_W'(i))) regs_d[i] = val_e;
         if (we_m && (dst_m == RA_W'(i))) regs_d[i] = val_m;
      end
   end

   // Register array storage, cleared on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Decode read ports
   always_comb begin
      rval_a = rd_port(src_a);
      rval_b = rd_port(src_b);
   end

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_dump
         assign reg_dump[gi*DATA_W +: DATA_W] = regs_q[gi];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/pipe_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module     : pipe_wb_regfile
// Description: Y86-64 writeback stage: W pipeline register (stall/bubble),
//              write-enable gating on W status, and the register file.
//              Optional macro WB_BYPASS_EN makes the read ports write-through.
// Revision   : 1.0 - initial release
// ============================================================================
module pipe_wb_regfile #(
   parameter int DATA_W = 64,
   parameter int NREG   = 15,
   parameter int RA_W   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   w_stall,
   input  logic                   w_bubble,
   input  logic [2:0]             m_stat,
   input  logic [3:0]             m_icode,
   input  logic [RA_W-1:0]        m_dstE,
   input  logic [RA_W-1:0]        m_dstM,
   input  logic [DATA_W-1:0]      m_valE,
   input  logic [DATA_W-1:0]      m_valM,
   input  logic [RA_W-1:0]        d_srcA,
   input  logic [RA_W-1:0]        d_srcB,
   output logic [DATA_W-1:0]      d_rvalA,
   output logic [DATA_W-1:0]      d_rvalB,
   output logic [2:0]             W_stat,
   output logic [3:0]             W_icode,
   output logic [RA_W-1:0]        W_dstE,
   output logic [RA_W-1:0]        W_dstM,
   output logic [DATA_W-1:0]      W_valE,
   output logic [DATA_W-1:0]      W_valM,
   output logic [NREG*DATA_W-1:0] reg_dump
);

   import y86_pkg::*;

   // "No register" index for this configuration, and NREG at comparison width
   localparam logic [RA_W-1:0] RNONE_IDX = RA_W'(NREG);
   localparam logic [RA_W:0]   NREG_L    = (RA_W+1)'(NREG);

   logic [2:0]        stat_q,  stat_d;
   logic [3:0]        icode_q, icode_d;
   logic [RA_W-1:0]   dste_q,  dste_d;
   logic [RA_W-1:0]   dstm_q,  dstm_d;
   logic [DATA_W-1:0] vale_q,  vale_d;
   logic [DATA_W-1:0] valm_q,  valm_d;

   logic w_ok;
   logic w_we_e;
   logic w_we_m;

   // W register next state: stall holds, bubble inserts a nop, else load from M
   always_comb begin
      stat_d  = stat_q;
      icode_d = icode_q;
      dste_d  = dste_q;
      dstm_d  = dstm_q;
      vale_d  = vale_q;
      valm_d  = valm_q;
      if (!w_stall) begin
         if (w_bubble) begin
            stat_d  = SBUB;
            icode_d = INOP;
            dste_d  = RNONE_IDX;
            dstm_d  = RNONE_IDX;
            vale_d  = '0;
            valm_d  = '0;
         end else begin
            stat_d  = m_stat;
            icode_d = m_icode;
            dste_d  = m_dstE;
            dstm_d  = m_dstM;
            vale_d  = m_valE;
            valm_d  = m_valM;
         end
      end
   end

   // W register; reset drops any in-flight instruction by forcing a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q  <= SBUB;
         icode_q <= INOP;
         dste_q  <= RNONE_IDX;
         dstm_q  <= RNONE_IDX;
         vale_q  <= '0;
         valm_q  <= '0;
      end else begin
         stat_q  <= stat_d;
         icode_q <= icode_d;
         dste_q  <= dste_d;
         dstm_q  <= dstm_d;
         vale_q  <= vale_d;
         valm_q  <= valm_d;
      end
   end

   // Only a normally completing instruction commits; out-of-range indices never write
   always_comb begin
      w_ok   = (stat_q == SAOK);
      w_we_e = w_ok && ({1'b0, dste_q} < NREG_L);
      w_we_m = w_ok && ({1'b0, dstm_q} < NREG_L);
   end

   y86_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG),
      .RA_W   (RA_W)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we_e     (w_we_e),
      .dst_e    (dste_q),
      .val_e    (vale_q),
      .we_m     (w_we_m),
      .dst_m    (dstm_q),
      .val_m    (valm_q),
      .src_a    (d_srcA),
      .src_b    (d_srcB),
      .rval_a   (d_rvalA),
      .rval_b   (d_rvalB),
      .reg_dump (reg_dump)
   );

   assign W_stat  = stat_q;
   assign W_icode = icode_q;
   assign W_dstE  = dste_q;
   assign W_dstM  = dstm_q;
   assign W_valE  = vale_q;
   assign W_valM  = valm_q;

endmodule
`default_nettype wire
